// File: rtl/kiwi_pkg.sv
// rtl/kiwi_pkg.sv - shared constants and types for the kiwi core slice
//
// Contents:
//   SCOREBOARD_SIZE_WIDTH : scoreboard id / producer tag width
//   KIWI_XLEN             : default operand and pc width
//   FC_JAL/FC_JALR/FC_BR  : branch unit func codes
//   operand_slot_t        : one source operand {rdy, tag, value}
package kiwi_pkg;

  localparam int SCOREBOARD_SIZE_WIDTH = 4;
  localparam int KIWI_XLEN             = 64;

  localparam logic [3:0] FC_JAL  = 4'b0111;
  localparam logic [3:0] FC_JALR = 4'b0101;
  localparam logic [3:0] FC_BR   = 4'b0100;

  typedef struct packed {
    logic                             rdy;
    logic [SCOREBOARD_SIZE_WIDTH-1:0] tag;
    logic [KIWI_XLEN-1:0]             value;
  } operand_slot_t;

endpackage

// File: rtl/biq_operand_slot.sv
// rtl/biq_operand_slot.sv - one source operand of an issue queue entry
//
// Holds {rdy, tag, value} for one operand, loads it at dispatch and
// captures the writeback broadcast when the producer tag matches.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   clear_i             : entry is squashed or issued; slot returns to empty
//   load_i              : entry is written by a dispatch this cycle
//   load_rdy_i/tag/value: dispatched operand state
//   entry_valid_i       : owning entry currently holds an op
//   wb_valid_i/sid/value: writeback broadcast
//   rdy_o, value_o      : current operand state
module biq_operand_slot #(
  parameter int SID_W = 4,
  parameter int XLEN  = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear_i,
  input  logic             load_i,
  input  logic             load_rdy_i,
  input  logic [SID_W-1:0] load_tag_i,
  input  logic [XLEN-1:0]  load_value_i,
  input  logic             entry_valid_i,
  input  logic             wb_valid_i,
  input  logic [SID_W-1:0] wb_sid_i,
  input  logic [XLEN-1:0]  wb_value_i,
  output logic             rdy_o,
  output logic [XLEN-1:0]  value_o
);

  logic             rdy_q;
  logic [SID_W-1:0] tag_q;
  logic [XLEN-1:0]  value_q;
  logic             load_hit;
  logic             wake_hit;

  // A broadcast in the dispatch cycle would otherwise be missed, since the
  // stored tag is not yet visible to the wakeup compare.
  assign load_hit = wb_valid_i & (wb_sid_i == load_tag_i);
  assign wake_hit = entry_valid_i & ~rdy_q & wb_valid_i & (wb_sid_i == tag_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy_q   <= 1'b0;
      tag_q   <= '0;
      value_q <= '0;
    end else if (clear_i) begin
      rdy_q   <= 1'b0;
      tag_q   <= '0;
      value_q <= '0;
    end else if (load_i) begin
      tag_q <= load_tag_i;
      if (load_rdy_i) begin
        rdy_q   <= 1'b1;
        value_q <= load_value_i;
      end else if (load_hit) begin
        rdy_q   <= 1'b1;
        value_q <= wb_value_i;
      end else begin
        rdy_q   <= 1'b0;
        value_q <= '0;
      end
    end else if (wake_hit) begin
      rdy_q   <= 1'b1;
      value_q <= wb_value_i;
    end
  end

  assign rdy_o   = rdy_q;
  assign value_o = value_q;

endmodule

// File: rtl/branch_issue_queue.sv
// rtl/branch_issue_queue.sv - in-order issue queue in front of the branch unit
//
// Buffers dispatched branch/jump ops in a circular buffer, wakes operands
// from the writeback broadcast and issues the head op once both operands
// are ready. flush_i / branch_redirect_i squash every queued op.
// Optional macro BIQ_BYPASS_EN: an op dispatched into an empty queue with
// both operands ready issues in the same cycle straight from disp_*.
// Ports:
//   clk, rst_n                 : clock, asynchronous active-low reset
//   flush_i, branch_redirect_i : squash all entries
//   disp_*                     : dispatch request / op fields, disp_ready_o
//   wb_valid_i/sid/value       : writeback broadcast
//   branch_valid_o, branch_*, rs1/rs2_value_o, func_code_o : issued op
module branch_issue_queue
  import kiwi_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int SID_W = SCOREBOARD_SIZE_WIDTH,
  parameter int XLEN  = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  input  logic             branch_redirect_i,
  input  logic             disp_valid_i,
  output logic             disp_ready_o,
  input  logic [XLEN-1:0]  disp_pc_i,
  input  logic [31:0]      disp_inst_i,
  input  logic [SID_W-1:0] disp_sid_i,
  input  logic [3:0]       disp_func_code_i,
  input  logic             disp_rs1_rdy_i,
  input  logic [SID_W-1:0] disp_rs1_tag_i,
  input  logic [XLEN-1:0]  disp_rs1_value_i,
  input  logic             disp_rs2_rdy_i,
  input  logic [SID_W-1:0] disp_rs2_tag_i,
  input  logic [XLEN-1:0]  disp_rs2_value_i,
  input  logic             wb_valid_i,
  input  logic [SID_W-1:0] wb_sid_i,
  input  logic [XLEN-1:0]  wb_value_i,
  output logic             branch_valid_o,
  output logic [XLEN-1:0]  branch_pc_o,
  output logic [31:0]      branch_inst_o,
  output logic [SID_W-1:0] branch_sid_o,
  output logic [XLEN-1:0]  rs1_value_o,
  output logic [XLEN-1:0]  rs2_value_o,
  output logic [3:0]       func_code_o
);

  localparam int             PTR_W      = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W+1)'(DEPTH);

  logic [PTR_W-1:0] head_q;
  logic [PTR_W-1:0] tail_q;
  logic [PTR_W:0]   count_q;

  logic [DEPTH-1:0] valid_q;
  logic [XLEN-1:0]  pc_q   [DEPTH];
  logic [31:0]      inst_q [DEPTH];
  logic [SID_W-1:0] sid_q  [DEPTH];
  logic [3:0]       func_q [DEPTH];
  logic [DEPTH-1:0] rs1_rdy;
  logic [DEPTH-1:0] rs2_rdy;
  logic [XLEN-1:0]  rs1_val [DEPTH];
  logic [XLEN-1:0]  rs2_val [DEPTH];

  logic squash;
  logic disp_fire;
  logic push;
  logic head_issue;
  logic bypass;

  assign squash       = flush_i | branch_redirect_i;
  assign disp_ready_o = (count_q != FULL_COUNT);
  assign disp_fire    = disp_valid_i & disp_ready_o & ~squash;
  // Everything queued is younger than the resolving branch, so a squash
  // also blocks the head from issuing.
  assign head_issue   = valid_q[head_q] & rs1_rdy[head_q] & rs2_rdy[head_q] & ~squash;

`ifdef BIQ_BYPASS_EN
  logic            byp_rs1_rdy;
  logic            byp_rs2_rdy;
  logic [XLEN-1:0] byp_rs1_value;
  logic [XLEN-1:0] byp_rs2_value;

  assign byp_rs1_rdy   = disp_rs1_rdy_i | (wb_valid_i & (wb_sid_i == disp_rs1_tag_i));
  assign byp_rs2_rdy   = disp_rs2_rdy_i | (wb_valid_i & (wb_sid_i == disp_rs2_tag_i));
  assign byp_rs1_value = disp_rs1_rdy_i ? disp_rs1_value_i : wb_value_i;
  assign byp_rs2_value = disp_rs2_rdy_i ? disp_rs2_value_i : wb_value_i;
  // Empty queue means nothing older can be waiting, so order is preserved.
  assign bypass        = disp_fire & (count_q == '0) & byp_rs1_rdy & byp_rs2_rdy;
`else
  assign bypass = 1'b0;
`endif

  assign push = disp_fire & ~bypass;

  // Pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else if (squash) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (head_issue) head_q <= head_q + PTR_W'(1);
      if (push)       tail_q <= tail_q + PTR_W'(1);
      case ({push, head_issue})
        2'b10:   count_q <= count_q + (PTR_W+1)'(1);
        2'b01:   count_q <= count_q - (PTR_W+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Entry payload. Issued and squashed entries are zeroed so an empty queue
  // presents zeros on the data outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        valid_q[i] <= 1'b0;
        pc_q[i]    <= '0;
        inst_q[i]  <= '0;
        sid_q[i]   <= '0;
        func_q[i]  <= '0;
      end
    end else if (squash) begin
      for (int i = 0; i < DEPTH; i++) begin
        valid_q[i] <= 1'b0;
        pc_q[i]    <= '0;
        inst_q[i]  <= '0;
        sid_q[i]   <= '0;
        func_q[i]  <= '0;
      end
    end else begin
      if (head_issue) begin
        valid_q[head_q] <= 1'b0;
        pc_q[head_q]    <= '0;
        inst_q[head_q]  <= '0;
        sid_q[head_q]   <= '0;
        func_q[head_q]  <= '0;
      end
      // Head and tail only coincide while the queue is empty (no issue) or
      // full (no push), so these two writes never target the same entry.
      if (push) begin
        valid_q[tail_q] <= 1'b1;
        pc_q[tail_q]    <= disp_pc_i;
        inst_q[tail_q]  <= disp_inst_i;
        sid_q[tail_q]   <= disp_sid_i;
        func_q[tail_q]  <= disp_func_code_i;
      end
    end
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_entry
    logic entry_clear;
    logic entry_load;

    assign entry_clear = squash | (head_issue & (head_q == PTR_W'(i)));
    assign entry_load  = push & (tail_q == PTR_W'(i));

    biq_operand_slot #(
      .SID_W (SID_W),
      .XLEN  (XLEN)
    ) u_rs1 (
      .clk           (clk),
      .rst_n         (rst_n),
      .clear_i       (entry_clear),
      .load_i        (entry_load),
      .load_rdy_i    (disp_rs1_rdy_i),
      .load_tag_i    (disp_rs1_tag_i),
      .load_value_i  (disp_rs1_value_i),
      .entry_valid_i (valid_q[i]),
      .wb_valid_i    (wb_valid_i),
      .wb_sid_i      (wb_sid_i),
      .wb_value_i    (wb_value_i),
      .rdy_o         (rs1_rdy[i]),
      .value_o       (rs1_val[i])
    );

    biq_operand_slot #(
      .SID_W (SID_W),
      .XLEN  (XLEN)
    ) u_rs2 (
      .clk           (clk),
      .rst_n         (rst_n),
      .clear_i       (entry_clear),
      .load_i        (entry_load),
      .load_rdy_i    (disp_rs2_rdy_i),
      .load_tag_i    (disp_rs2_tag_i),
      .load_value_i  (disp_rs2_value_i),
      .entry_valid_i (valid_q[i]),
      .wb_valid_i    (wb_valid_i),
      .wb_sid_i      (wb_sid_i),
      .wb_value_i    (wb_value_i),
      .rdy_o         (rs2_rdy[i]),
      .value_o       (rs2_val[i])
    );
  end

  // Issue outputs are combinational; the branch unit registers them.
  always_comb begin
    branch_valid_o = head_issue | bypass;
    branch_pc_o    = pc_q[head_q];
    branch_inst_o  = inst_q[head_q];
    branch_sid_o   = sid_q[head_q];
    func_code_o    = func_q[head_q];
    rs1_value_o    = rs1_val[head_q];
    rs2_value_o    = rs2_val[head_q];
`ifdef BIQ_BYPASS_EN
    if (bypass) begin
      branch_pc_o   = disp_pc_i;
      branch_inst_o = disp_inst_i;
      branch_sid_o  = disp_sid_i;
      func_code_o   = disp_func_code_i;
      rs1_value_o   = byp_rs1_value;
      rs2_value_o   = byp_rs2_value;
    end
`endif
  end

endmodule

// File: tb/tb_branch_issue_queue.sv
// tb/tb_branch_issue_queue.sv - self-checking bench for branch_issue_queue
module tb_branch_issue_queue;
  import kiwi_pkg::*;

  localparam int DEPTH = 4;
  localparam int SID_W = SCOREBOARD_SIZE_WIDTH;
  localparam int XLEN  = 64;
`ifdef BIQ_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n;
  logic             flush_i, branch_redirect_i;
  logic             disp_valid_i, disp_ready_o;
  logic [XLEN-1:0]  disp_pc_i;
  logic [31:0]      disp_inst_i;
  logic [SID_W-1:0] disp_sid_i;
  logic [3:0]       disp_func_code_i;
  logic             disp_rs1_rdy_i, disp_rs2_rdy_i;
  logic [SID_W-1:0] disp_rs1_tag_i, disp_rs2_tag_i;
  logic [XLEN-1:0]  disp_rs1_value_i, disp_rs2_value_i;
  logic             wb_valid_i;
  logic [SID_W-1:0] wb_sid_i;
  logic [XLEN-1:0]  wb_value_i;
  logic             branch_valid_o;
  logic [XLEN-1:0]  branch_pc_o;
  logic [31:0]      branch_inst_o;
  logic [SID_W-1:0] branch_sid_o;
  logic [XLEN-1:0]  rs1_value_o, rs2_value_o;
  logic [3:0]       func_code_o;

  always #5 clk = ~clk;

  branch_issue_queue #(.DEPTH(DEPTH), .SID_W(SID_W), .XLEN(XLEN)) dut (
    .clk(clk), .rst_n(rst_n), .flush_i(flush_i), .branch_redirect_i(branch_redirect_i),
    .disp_valid_i(disp_valid_i), .disp_ready_o(disp_ready_o), .disp_pc_i(disp_pc_i),
    .disp_inst_i(disp_inst_i), .disp_sid_i(disp_sid_i), .disp_func_code_i(disp_func_code_i),
    .disp_rs1_rdy_i(disp_rs1_rdy_i), .disp_rs1_tag_i(disp_rs1_tag_i),
    .disp_rs1_value_i(disp_rs1_value_i), .disp_rs2_rdy_i(disp_rs2_rdy_i),
    .disp_rs2_tag_i(disp_rs2_tag_i), .disp_rs2_value_i(disp_rs2_value_i),
    .wb_valid_i(wb_valid_i), .wb_sid_i(wb_sid_i), .wb_value_i(wb_value_i),
    .branch_valid_o(branch_valid_o), .branch_pc_o(branch_pc_o), .branch_inst_o(branch_inst_o),
    .branch_sid_o(branch_sid_o), .rs1_value_o(rs1_value_o), .rs2_value_o(rs2_value_o),
    .func_code_o(func_code_o)
  );

  // Reference model: the queue contents in program order.
  typedef struct {
    logic [XLEN-1:0]  pc;
    logic [31:0]      inst;
    logic [SID_W-1:0] sid;
    logic [3:0]       func;
    operand_slot_t    r1;
    operand_slot_t    r2;
  } mentry_t;

  mentry_t mq[$];
  mentry_t m_new;
  bit      m_sq, m_acc, m_byp, m_iss;
  int      n_checks = 0;
  int      n_fail   = 0;
  int      cyc      = 0;

  typedef struct {
    logic dv; logic [15:0] pc; logic [3:0] sid; logic [3:0] fc;
    logic r1r; logic [3:0] r1t; logic [7:0] r1v;
    logic r2r; logic [3:0] r2t; logic [7:0] r2v;
    logic wv; logic [3:0] ws; logic [7:0] wval;
    logic e_v; logic [15:0] e_pc; logic [3:0] e_sid; logic [7:0] e_rs1; logic [7:0] e_rs2;
    int e_cnt;
  } vec_t;

  vec_t tbl[$];
  vec_t v;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: actual %0h required %0h", name, cyc, act, exp);
    end
  endtask

  function automatic operand_slot_t mk_op(input logic rdy, input logic [SID_W-1:0] tag,
                                          input logic [XLEN-1:0] val);
    operand_slot_t o;
    o.tag = tag;
    if (rdy) begin
      o.rdy = 1'b1; o.value = val;
    end else if (wb_valid_i && wb_sid_i == tag) begin
      o.rdy = 1'b1; o.value = wb_value_i;
    end else begin
      o.rdy = 1'b0; o.value = '0;
    end
    return o;
  endfunction

  function automatic operand_slot_t wake(input operand_slot_t o);
    operand_slot_t r = o;
    if (!r.rdy && wb_valid_i && r.tag == wb_sid_i) begin
      r.rdy = 1'b1; r.value = wb_value_i;
    end
    return r;
  endfunction

  // Inputs are applied at the falling edge; settle, then compare against
  // what the model says this cycle must look like.
  task automatic check_model();
    mentry_t h;
    #2;
    m_sq  = flush_i || branch_redirect_i;
    m_acc = disp_valid_i && (mq.size() < DEPTH) && !m_sq;
    m_new.pc   = disp_pc_i;
    m_new.inst = disp_inst_i;
    m_new.sid  = disp_sid_i;
    m_new.func = disp_func_code_i;
    m_new.r1   = mk_op(disp_rs1_rdy_i, disp_rs1_tag_i, disp_rs1_value_i);
    m_new.r2   = mk_op(disp_rs2_rdy_i, disp_rs2_tag_i, disp_rs2_value_i);
    m_byp = BYP && m_acc && (mq.size() == 0) && m_new.r1.rdy && m_new.r2.rdy;
    m_iss = !m_sq && (mq.size() > 0) && mq[0].r1.rdy && mq[0].r2.rdy;
    chk("model_ready", 64'(disp_ready_o), 64'(mq.size() < DEPTH));
    chk("model_count", 64'(dut.count_q), 64'(mq.size()));
    chk("model_valid", 64'(branch_valid_o), 64'(m_iss || m_byp));
    if (m_iss || m_byp) begin
      if (m_byp) h = m_new;
      else       h = mq[0];
      chk("model_pc",   branch_pc_o, h.pc);
      chk("model_inst", 64'(branch_inst_o), 64'(h.inst));
      chk("model_sid",  64'(branch_sid_o), 64'(h.sid));
      chk("model_func", 64'(func_code_o), 64'(h.func));
      chk("model_rs1",  rs1_value_o, h.r1.value);
      chk("model_rs2",  rs2_value_o, h.r2.value);
    end
  endtask

  task automatic advance();
    @(posedge clk);
    if (m_sq) begin
      mq.delete();
    end else begin
      if (m_iss) void'(mq.pop_front());
      for (int k = 0; k < mq.size(); k++) begin
        mq[k].r1 = wake(mq[k].r1);
        mq[k].r2 = wake(mq[k].r2);
      end
      if (m_acc && !m_byp) mq.push_back(m_new);
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic step();
    check_model();
    advance();
  endtask

  task automatic set_idle();
    flush_i = 1'b0; branch_redirect_i = 1'b0;
    disp_valid_i = 1'b0; disp_pc_i = '0; disp_inst_i = '0; disp_sid_i = '0;
    disp_func_code_i = '0; disp_rs1_rdy_i = 1'b0; disp_rs1_tag_i = '0; disp_rs1_value_i = '0;
    disp_rs2_rdy_i = 1'b0; disp_rs2_tag_i = '0; disp_rs2_value_i = '0;
    wb_valid_i = 1'b0; wb_sid_i = '0; wb_value_i = '0;
  endtask

  task automatic set_disp(input logic [63:0] pc, input logic [3:0] sid, input logic [3:0] fc,
                          input logic r1r, input logic [3:0] r1t, input logic [63:0] r1v,
                          input logic r2r, input logic [3:0] r2t, input logic [63:0] r2v);
    disp_valid_i = 1'b1; disp_pc_i = pc; disp_inst_i = pc[31:0] ^ 32'h0000_0063;
    disp_sid_i = sid; disp_func_code_i = fc;
    disp_rs1_rdy_i = r1r; disp_rs1_tag_i = r1t; disp_rs1_value_i = r1v;
    disp_rs2_rdy_i = r2r; disp_rs2_tag_i = r2t; disp_rs2_value_i = r2v;
  endtask

  initial begin
    set_idle();
    rst_n = 1'b0;

    // Directed vectors: ready in order, wakeup holding the head, same-cycle wakeup.
    //            dv   pc        sid   fc      r1r  r1t   r1v    r2r  r2t   r2v    wv   ws    wval   e_v   e_pc  e_sid e_rs1 e_rs2 e_cnt
    tbl.push_back('{1'b1, 16'h1000, 4'd1, FC_JAL, 1'b1, 4'd0, 8'h11, 1'b1, 4'd0, 8'h12, 1'b0, 4'd0, 8'h00,
                    BYP, 16'h1000, 4'd1, 8'h11, 8'h12, 0});
    tbl.push_back('{1'b1, 16'h1004, 4'd2, FC_BR,  1'b1, 4'd0, 8'h22, 1'b1, 4'd0, 8'h23, 1'b0, 4'd0, 8'h00,
                    1'b1, BYP ? 16'h1004 : 16'h1000, BYP ? 4'd2 : 4'd1, BYP ? 8'h22 : 8'h11,
                    BYP ? 8'h23 : 8'h12, BYP ? 0 : 1});
    tbl.push_back('{1'b0, 16'h0, 4'd0, 4'h0, 1'b0, 4'd0, 8'h0, 1'b0, 4'd0, 8'h0, 1'b0, 4'd0, 8'h00,
                    !BYP, 16'h1004, 4'd2, 8'h22, 8'h23, BYP ? 0 : 1});
    tbl.push_back('{1'b0, 16'h0, 4'd0, 4'h0, 1'b0, 4'd0, 8'h0, 1'b0, 4'd0, 8'h0, 1'b0, 4'd0, 8'h00,
                    1'b0, 16'h0, 4'd0, 8'h0, 8'h0, 0});
    tbl.push_back('{1'b1, 16'h2000, 4'd4, FC_BR,  1'b0, 4'd3, 8'h00, 1'b1, 4'd0, 8'h44, 1'b0, 4'd0, 8'h00,
                    1'b0, 16'h0, 4'd0, 8'h0, 8'h0, 0});
    tbl.push_back('{1'b1, 16'h2004, 4'd6, FC_JAL, 1'b1, 4'd0, 8'h77, 1'b1, 4'd0, 8'h78, 1'b0, 4'd0, 8'h00,
                    1'b0, 16'h0, 4'd0, 8'h0, 8'h0, 1});
    tbl.push_back('{1'b0, 16'h0, 4'd0, 4'h0, 1'b0, 4'd0, 8'h0, 1'b0, 4'd0, 8'h0, 1'b0, 4'd0, 8'h00,
                    1'b0, 16'h0, 4'd0, 8'h0, 8'h0, 2});
    tbl.push_back('{1'b0, 16'h0, 4'd0, 4'h0, 1'b0, 4'd0, 8'h0, 1'b0, 4'd0, 8'h0, 1'b1, 4'd3, 8'h55,
                    1'b0, 16'h0, 4'd0, 8'h0, 8'h0, 2});
    tbl.push_back('{1'b0, 16'h0, 4'd0, 4'h0, 1'b0, 4'd0, 8'h0, 1'b0, 4'd0, 8'h0, 1'b0, 4'd0, 8'h00,
                    1'b1, 16'h2000, 4'd4, 8'h55, 8'h44, 2});
    tbl.push_back('{1'b0, 16'h0, 4'd0, 4'h0, 1'b0, 4'd0, 8'h0, 1'b0, 4'd0, 8'h0, 1'b0, 4'd0, 8'h00,
                    1'b1, 16'h2004, 4'd6, 8'h77, 8'h78, 1});
    tbl.push_back('{1'b0, 16'h0, 4'd0, 4'h0, 1'b0, 4'd0, 8'h0, 1'b0, 4'd0, 8'h0, 1'b0, 4'd0, 8'h00,
                    1'b0, 16'h0, 4'd0, 8'h0, 8'h0, 0});
    tbl.push_back('{1'b1, 16'h3000, 4'd7, FC_BR,  1'b1, 4'd0, 8'h01, 1'b0, 4'd5, 8'h00, 1'b1, 4'd5, 8'hAA,
                    BYP, 16'h3000, 4'd7, 8'h01, 8'hAA, 0});
    tbl.push_back('{1'b0, 16'h0, 4'd0, 4'h0, 1'b0, 4'd0, 8'h0, 1'b0, 4'd0, 8'h0, 1'b0, 4'd0, 8'h00,
                    !BYP, 16'h3000, 4'd7, 8'h01, 8'hAA, BYP ? 0 : 1});
    tbl.push_back('{1'b0, 16'h0, 4'd0, 4'h0, 1'b0, 4'd0, 8'h0, 1'b0, 4'd0, 8'h0, 1'b0, 4'd0, 8'h00,
                    1'b0, 16'h0, 4'd0, 8'h0, 8'h0, 0});

    // Reset state
    repeat (2) @(negedge clk);
    #2;
    chk("reset_ready", 64'(disp_ready_o), 64'd1);
    chk("reset_valid", 64'(branch_valid_o), 64'd0);
    chk("reset_count", 64'(dut.count_q), 64'd0);
    chk("reset_pc", branch_pc_o, 64'd0);
    chk("reset_sid", 64'(branch_sid_o), 64'd0);
    chk("reset_rs1", rs1_value_o, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int r = 0; r < tbl.size(); r++) begin
      v = tbl[r];
      set_idle();
      disp_valid_i = v.dv; disp_pc_i = {48'h0, v.pc}; disp_inst_i = {16'h0, v.pc} ^ 32'h0000_0063;
      disp_sid_i = v.sid; disp_func_code_i = v.fc;
      disp_rs1_rdy_i = v.r1r; disp_rs1_tag_i = v.r1t; disp_rs1_value_i = {56'h0, v.r1v};
      disp_rs2_rdy_i = v.r2r; disp_rs2_tag_i = v.r2t; disp_rs2_value_i = {56'h0, v.r2v};
      wb_valid_i = v.wv; wb_sid_i = v.ws; wb_value_i = {56'h0, v.wval};
      check_model();
      chk($sformatf("vec%0d_valid", r), 64'(branch_valid_o), 64'(v.e_v));
      chk($sformatf("vec%0d_count", r), 64'(dut.count_q), 64'(v.e_cnt));
      if (v.e_v) begin
        chk($sformatf("vec%0d_pc", r), branch_pc_o, {48'h0, v.e_pc});
        chk($sformatf("vec%0d_sid", r), 64'(branch_sid_o), 64'(v.e_sid));
        chk($sformatf("vec%0d_rs1", r), rs1_value_o, {56'h0, v.e_rs1});
        chk($sformatf("vec%0d_rs2", r), rs2_value_o, {56'h0, v.e_rs2});
      end
      advance();
    end

    // Full queue: no dispatch accepted while full, even in an issuing cycle.
    set_idle();
    for (int i = 0; i < 4; i++) begin
      set_disp(64'h4000 + 64'(4 * i), 4'(8 + i), FC_BR, 1'b0, 4'(8 + i), 64'h0, 1'b1, 4'h0, 64'(100 + i));
      step();
    end
    set_disp(64'h4010, 4'd12, FC_JALR, 1'b1, 4'd0, 64'h1, 1'b1, 4'd0, 64'h2);
    check_model();
    chk("full_not_ready", 64'(disp_ready_o), 64'd0);
    advance();
    wb_valid_i = 1'b1; wb_sid_i = 4'd8; wb_value_i = 64'h99;
    check_model();
    chk("full_count", 64'(dut.count_q), 64'd4);
    advance();
    wb_valid_i = 1'b0;
    check_model();
    chk("full_head_issues", 64'(branch_valid_o), 64'd1);
    chk("full_head_rs1", rs1_value_o, 64'h99);
    chk("full_no_accept_on_issue", 64'(disp_ready_o), 64'd0);
    advance();
    set_idle();
    check_model();
    chk("ready_after_issue", 64'(disp_ready_o), 64'd1);
    chk("count_after_issue", 64'(dut.count_q), 64'd3);
    advance();

    // Flush, then redirect with three entries queued and a ready head.
    flush_i = 1'b1;
    step();
    set_idle();
    set_disp(64'h5000, 4'd1, FC_BR,   1'b0, 4'd12, 64'h0, 1'b1, 4'd0, 64'h5);
    step();
    set_disp(64'h5004, 4'd2, FC_JAL,  1'b1, 4'd0, 64'h6, 1'b1, 4'd0, 64'h7);
    step();
    set_disp(64'h5008, 4'd3, FC_JALR, 1'b1, 4'd0, 64'h8, 1'b1, 4'd0, 64'h9);
    step();
    set_idle();
    wb_valid_i = 1'b1; wb_sid_i = 4'd12; wb_value_i = 64'h1234;
    step();
    set_idle();
    set_disp(64'h500C, 4'd5, FC_BR, 1'b1, 4'd0, 64'hA, 1'b1, 4'd0, 64'hB);
    branch_redirect_i = 1'b1;
    check_model();
    chk("redirect_gates_issue", 64'(branch_valid_o), 64'd0);
    advance();
    set_idle();
    check_model();
    chk("redirect_clears_count", 64'(dut.count_q), 64'd0);
    chk("redirect_drops_dispatch", 64'(branch_valid_o), 64'd0);
    advance();

    // Asynchronous reset with ops in flight.
    set_disp(64'h6000, 4'd1, FC_BR, 1'b0, 4'd13, 64'h0, 1'b0, 4'd14, 64'h0);
    step();
    step();
    set_idle();
    rst_n = 1'b0;
    #1;
    chk("async_reset_count", 64'(dut.count_q), 64'd0);
    chk("async_reset_ready", 64'(disp_ready_o), 64'd1);
    chk("async_reset_valid", 64'(branch_valid_o), 64'd0);
    mq.delete();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      set_idle();
      disp_valid_i      = ($urandom_range(0, 9) < 6);
      disp_pc_i         = {$urandom(), $urandom()};
      disp_inst_i       = $urandom();
      disp_sid_i        = SID_W'($urandom_range(0, 15));
      disp_func_code_i  = ($urandom_range(0, 2) == 0) ? FC_JAL : (($urandom_range(0, 1) == 0) ? FC_JALR : FC_BR);
      disp_rs1_rdy_i    = ($urandom_range(0, 9) < 6);
      disp_rs1_tag_i    = SID_W'($urandom_range(0, 3));
      disp_rs1_value_i  = {$urandom(), $urandom()};
      disp_rs2_rdy_i    = ($urandom_range(0, 9) < 6);
      disp_rs2_tag_i    = SID_W'($urandom_range(0, 3));
      disp_rs2_value_i  = {$urandom(), $urandom()};
      wb_valid_i        = ($urandom_range(0, 9) < 4);
      wb_sid_i          = SID_W'($urandom_range(0, 3));
      wb_value_i        = {$urandom(), $urandom()};
      flush_i           = ($urandom_range(0, 99) < 3);
      branch_redirect_i = ($urandom_range(0, 99) < 3);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/branch_issue_queue.md
Name: branch_issue_queue

Overview:
- In-order issue queue and scheduler in front of the branch execution unit.
- Buffers dispatched branch/jump ops and captures operand values from the writeback broadcast.
- Issues the oldest op to the branch execution unit once both of its operands are ready.
- Squashes all queued ops on a pipeline flush or a branch redirect.

Parameters:
DEPTH, 4, number of queue entries (power of 2, >=2)
SID_W, `SCOREBOARD_SIZE_WIDTH, scoreboard id / producer tag width
XLEN, 64, operand and pc width

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
flush_i  in  1  pipeline flush; squashes all entries
branch_redirect_i  in  1  branch execution unit redirect; squashes all entries
disp_valid_i  in  1  dispatch request
disp_ready_o  out  1  queue can accept a dispatch
disp_pc_i  in  XLEN  op pc
disp_inst_i  in  32  op instruction
disp_sid_i  in  SID_W  op scoreboard id
disp_func_code_i  in  4  func code (JAL/JALR/BR)
disp_rsN_rdy_i  in  1  rsN value valid at dispatch (N=1,2)
disp_rsN_tag_i  in  SID_W  producer sid of rsN if not ready
disp_rsN_value_i  in  XLEN  rsN value if ready
wb_valid_i  in  1  writeback broadcast valid
wb_sid_i  in  SID_W  broadcasting producer sid
wb_value_i  in  XLEN  broadcast value
branch_valid_o  out  1  issue to branch execution unit
branch_pc_o  out  XLEN  issued pc
branch_inst_o  out  32  issued inst
branch_sid_o  out  SID_W  issued sid
rs1_value_o / rs2_value_o  out  XLEN  issued operands
func_code_o  out  4  issued func code

Behaviour:
- Reset: all entry valid bits 0; head, tail and count 0; branch_valid_o=0; disp_ready_o=1; data outputs 0.
- Storage: circular buffer with head/tail pointers of log2(DEPTH) bits, wrapping modulo DEPTH, and a count of log2(DEPTH)+1 bits.
- Entry fields: valid, pc, inst, sid, func, and rs1/rs2 {rdy, tag, value}.
- Dispatch handshake:
  - disp_ready_o = (count != DEPTH), from registered state only.
  - An entry is written at tail when disp_valid_i & disp_ready_o & !flush_i & !branch_redirect_i.
  - When full, no dispatch is accepted even if an issue occurs in the same cycle.
- Wakeup:
  - Every valid entry with rsN_rdy=0 and rsN_tag==wb_sid_i under wb_valid_i sets rsN_rdy=1 and captures wb_value_i.
  - The entry being written in the same cycle also compares its incoming tags against the broadcast, so a same-cycle wakeup is not lost.
- Issue:
  - Only the head entry may issue, enforcing strict program order.
  - Condition: head valid & rs1_rdy & rs2_rdy & !flush_i & !branch_redirect_i.
  - Outputs are combinational from the head entry; the branch execution unit registers them.
  - On issue the head entry is cleared and head increments.
  - One issue per cycle; no backpressure from the branch execution unit.
- Simultaneous dispatch and issue: count is unchanged and both pointers advance.
- Squash: flush_i or branch_redirect_i clears every valid bit and sets head=tail=count=0 on the next edge.
  - Issue is gated off in that cycle, because every queued op is younger than the resolving branch.
  - A dispatch in the same cycle is dropped.
- Reset mid-operation: state returns asynchronously to reset values; any in-flight issue is lost.
- Branch-type ops (func BR) ignore rd; the queue itself does not interpret func beyond passing it through.

Optional Feature:
- Macro: BIQ_BYPASS_EN.
- Defined: when the queue is empty, a dispatched op with both operands ready (including via a same-cycle wakeup) is issued in the same cycle directly from the disp_* inputs. Conditions: accepted dispatch, no flush, no redirect. The op is not written and the pointers do not move.
- Undefined: every op spends at least one cycle in the queue, so minimum dispatch-to-issue latency is 1 cycle.

Decomposition:
- Shared package (kiwi_pkg) holds:
  - Func codes: FC_JAL=4'b0111, FC_JALR=4'b0101, FC_BR=4'b0100.
  - SCOREBOARD_SIZE_WIDTH.
  - The operand-slot struct {rdy, tag, value}.
- One sub-module, biq_operand_slot: holds one operand, performs tag compare and capture, and is instantiated 2*DEPTH times.

Test Plan:
1. Ready in order: dispatch JAL pc=0x1000, both ready, then BR pc=0x1004, both ready -> issues in consecutive cycles, JAL first, branch_sid_o matches dispatch sids, count returns to 0.
2. Wakeup holds head:
   - Dispatch BR with rs1 tag=3 not ready, then JAL ready -> neither issues.
   - Broadcast wb_sid=3, value=0x55 -> BR issues the next cycle with rs1_value_o=0x55, JAL the following cycle.
3. Same-cycle wakeup: dispatch with rs2 tag=5 while wb_sid_i=5, value=0xAA -> entry captures 0xAA and issues; no hang.
4. Full queue: dispatch 4 unready ops -> disp_ready_o=0. A fifth disp_valid_i is not accepted. Wake the head -> it issues, and disp_ready_o=1 the next cycle.
5. Redirect: 3 entries queued with ready head, assert branch_redirect_i with disp_valid_i=1 -> branch_valid_o=0 that cycle; next cycle count=0 and the dispatch is dropped.
6. BIQ_BYPASS_EN: with the queue empty, dispatch a ready op -> branch_valid_o=1 in the same cycle and count stays 0. Without the macro -> issue 1 cycle later.
